fetch_stream: RTL

Parametrised successor to the single-register fetch stage: a pipelined instruction fetch unit that keeps up to DEPTH requests in flight to a latency-tolerant instruction memory. It buffers returned words in order with their PCs and hands them to decode over a valid/ready handshake. It supports branch redirect with squash of stale in-flight responses. It sits between the PC-select logic and the decode stage.

---
 rtl/fetch_pkg.sv | 11 +
 rtl/fetch_stream_if.sv | 32 +++
 rtl/fetch_slot_buffer.sv | 85 ++++++++
 rtl/fetch_stream.sv | 89 ++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the pipelined fetch unit: PC step derivation and reset defaults.
package fetch_pkg;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // The PC is byte addressed, so one instruction advances it by its size in bytes.
   function automatic int unsigned inc_bytes(input int unsigned iw);
      return iw / 8;
   endfunction

endpackage

// File: rtl/fetch_stream_if.sv
// Fetch-unit bus: request/response channel to instruction memory plus the decode handshake.
interface fetch_stream_if #(
   parameter int AW = 32,
   parameter int IW = 32
);
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_gnt;
   logic          imem_rvalid;
   logic [IW-1:0] imem_rdata;

   logic          inst_valid;
   logic          inst_ready;
   logic [IW-1:0] inst;
   logic [AW-1:0] inst_pc;
   logic [AW-1:0] inst_pc_next;

   // master is the fetch unit; slave is the memory plus decode side
   modport master (
      output imem_req, imem_addr,
      input  imem_gnt, imem_rvalid, imem_rdata,
      output inst_valid, inst, inst_pc, inst_pc_next,
      input  inst_ready
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_gnt, imem_rvalid, imem_rdata,
      input  inst_valid, inst, inst_pc, inst_pc_next,
      output inst_ready
   );
endinterface

// File: rtl/fetch_slot_buffer.sv
// In-order slot buffer: slots are allocated at request grant, filled by responses and
// retired to decode; all three pointers carry a wrap bit so level/pending are plain differences.
module fetch_slot_buffer #(
   parameter int AW    = 32,
   parameter int IW    = 32,
   parameter int DEPTH = 4,
   localparam int PW   = $clog2(DEPTH),
   localparam int LW   = PW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   input  logic          alloc_en,
   input  logic [AW-1:0] alloc_pc,
   input  logic          fill_en,
   input  logic [IW-1:0] fill_word,
   input  logic          retire_en,
   output logic          head_valid,
   output logic [AW-1:0] head_pc,
   output logic [IW-1:0] head_word,
   output logic [LW-1:0] level,
   output logic [LW-1:0] pending
);

   typedef struct packed {
      logic [AW-1:0] pc;
      logic [IW-1:0] word;
      logic          filled;
   } slot_t;

   logic [PW:0] alloc_ptr_reg;
   logic [PW:0] fill_ptr_reg;
   logic [PW:0] head_ptr_reg;
   slot_t       slot_view [DEPTH];
   slot_t       head_slot;

   // Alloc and fill never target the same slot in one cycle: fill needs pending>0
   // and alloc needs level<DEPTH, so their indices always differ.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      slot_t slot_reg;

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            slot_reg <= '0;
         end else if (flush) begin
            slot_reg <= '0;
         end else if (alloc_en && (alloc_ptr_reg[PW-1:0] == PW'(gi))) begin
            slot_reg.pc     <= alloc_pc;
            slot_reg.word   <= '0;
            slot_reg.filled <= 1'b0;
         end else if (fill_en && (fill_ptr_reg[PW-1:0] == PW'(gi))) begin
            slot_reg.word   <= fill_word;
            slot_reg.filled <= 1'b1;
         end
      end

      assign slot_view[gi] = slot_reg;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         alloc_ptr_reg <= '0;
         fill_ptr_reg  <= '0;
         head_ptr_reg  <= '0;
      end else if (flush) begin
         alloc_ptr_reg <= '0;
         fill_ptr_reg  <= '0;
         head_ptr_reg  <= '0;
      end else begin
         alloc_ptr_reg <= alloc_ptr_reg + LW'(alloc_en);
         fill_ptr_reg  <= fill_ptr_reg + LW'(fill_en);
         head_ptr_reg  <= head_ptr_reg + LW'(retire_en);
      end
   end

   assign level     = alloc_ptr_reg - head_ptr_reg;
   assign pending   = alloc_ptr_reg - fill_ptr_reg;
   assign head_slot = slot_view[head_ptr_reg[PW-1:0]];

   // A retired slot keeps its filled flag, so an empty buffer must mask it.
   assign head_valid = head_slot.filled & (level != '0);
   assign head_pc    = head_slot.pc;
   assign head_word  = head_slot.word;

endmodule

// File: rtl/fetch_stream.sv
// Pipelined instruction fetch: keeps up to DEPTH requests in flight, delivers words in
// order with their PCs, and squashes responses that belong to a redirected-away stream.
module fetch_stream
   import fetch_pkg::*;
#(
   parameter int            AW       = 32,
   parameter int            IW       = 32,
   parameter int            DEPTH    = 4,
   parameter logic [AW-1:0] RESET_PC = AW'(DEFAULT_RESET_PC)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         redirect_valid,
   input  logic [AW-1:0]                redirect_pc,
   fetch_stream_if.master               bus,
   output logic [$clog2(DEPTH+1)-1:0]   level
);

   localparam int            LW  = $clog2(DEPTH + 1);
   localparam int            CW  = $clog2(2 * DEPTH + 1);
   localparam logic [AW-1:0] INC = AW'(inc_bytes(IW));

   logic [AW-1:0] fetch_pc_reg;
   logic [AW-1:0] fetch_pc_next;
   logic [CW-1:0] drop_cnt_reg;
   logic [CW-1:0] drop_cnt_next;
   logic          grant;
   logic          resp_keep;
   logic          resp_drop;
   logic          retire;
   logic [LW-1:0] pending;
   logic [AW-1:0] head_pc;

   assign bus.imem_req  = reset & (level < LW'(DEPTH));
   assign bus.imem_addr = fetch_pc_reg;

   assign grant     = bus.imem_req & bus.imem_gnt;
   assign resp_drop = bus.imem_rvalid & (drop_cnt_reg != '0);
   assign resp_keep = bus.imem_rvalid & (drop_cnt_reg == '0);
   assign retire    = bus.inst_valid & bus.inst_ready;

   // On redirect every response still owed by memory becomes stale: unfilled slots,
   // this cycle's grant and the backlog already marked for discard, less what arrives now.
   always_comb begin
      fetch_pc_next = fetch_pc_reg;
      drop_cnt_next = drop_cnt_reg - CW'(resp_drop);
      if (redirect_valid) begin
         fetch_pc_next = redirect_pc;
         drop_cnt_next = drop_cnt_reg + CW'(pending) + CW'(grant)
                         - CW'(resp_keep) - CW'(resp_drop);
      end else if (grant) begin
         fetch_pc_next = fetch_pc_reg + INC;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc_reg <= RESET_PC;
         drop_cnt_reg <= '0;
      end else begin
         fetch_pc_reg <= fetch_pc_next;
         drop_cnt_reg <= drop_cnt_next;
      end
   end

   fetch_slot_buffer #(
      .AW    (AW),
      .IW    (IW),
      .DEPTH (DEPTH)
   ) u_slots (
      .clk        (clk),
      .reset      (reset),
      .flush      (redirect_valid),
      .alloc_en   (grant),
      .alloc_pc   (fetch_pc_reg),
      .fill_en    (resp_keep),
      .fill_word  (bus.imem_rdata),
      .retire_en  (retire),
      .head_valid (bus.inst_valid),
      .head_pc    (head_pc),
      .head_word  (bus.inst),
      .level      (level),
      .pending    (pending)
   );

   assign bus.inst_pc      = head_pc;
   assign bus.inst_pc_next = head_pc + INC;

endmodule
